ysyx_22040729_lsu: RTL
======================

# ysyx_22040729_lsu

Parametrised load/store unit between the core execute stage and a handshaked data memory port. Accepts one access (byte/half/word/double, signed or unsigned) and issues a single aligned memory beat with byte strobes. Returns lane-aligned, sign/zero-extended read data through a multi-cycle FSM that tolerates memory back-pressure and variable response latency. Replaces the fixed single-cycle combinational load/store path so the core can run against non-ideal memories.

## Interface
- DATA_WIDTH, 64: data bus width, 32 or 64; bytes per beat NB = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core access request.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_func3  in  3  [1:0] size (0=B,1=H,2=W,3=D); [2] unsigned load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse; no back-pressure.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  access not performed (see Configuration, illegal size).
- mem_req_valid  out  1  memory beat request.
- mem_req_ready  in  1  memory accepts beat.
- mem_req_wen  out  1  beat is a write.
- mem_req_addr  out  ADDR_WIDTH  beat address, low log2(NB) bits zero.
- mem_req_wstrb  out  NB  byte enables (loads too, informational).
- mem_req_wdata  out  DATA_WIDTH  lane-shifted store data.
- mem_resp_valid  in  1  beat complete (read data valid / write done).
- mem_resp_rdata  in  DATA_WIDTH  full aligned read beat.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch wen, func3, addr, wdata. If illegal (size 3 with DATA_WIDTH=32, or misaligned with macro) -> RESP with err=1; else -> REQ.
- REQ: mem_req_valid=1, all mem_req_* held stable; on mem_req_ready -> WAIT.
- WAIT: on mem_resp_valid -> RESP, latch extended read data; mem_resp_valid ignored in all other states.
- RESP: resp_valid=1 one cycle -> IDLE.
- off = addr[log2(NB)-1:0]; bytes = 1<<size; mem_req_wstrb = ((1<<bytes)-1)<<off truncated to NB; mem_req_wdata = req_wdata << (8*off).
- Load: shift beat right by 8*off, keep 8*bytes bits, sign-extend from top kept bit unless func3[2]; size 3 ignores func3[2].
- Without macro, off is forced to a multiple of bytes (low log2(bytes) bits cleared) before use.

## Timing
- Reset: state IDLE; req_ready=1; resp_valid, resp_err, mem_req_valid, mem_req_wen=0; resp_rdata, mem_req_addr, mem_req_wstrb, mem_req_wdata=0.
- Accept cycle N -> mem_req_valid from N+1; zero-wait memory (ready at N+1, resp at N+2) -> resp_valid at N+3. Error path -> resp_valid at N+1.
- At most one access in flight; req_ready low from N+1 through the resp_valid cycle.
- Memory must not assert mem_resp_valid in the same cycle as mem_req_ready.
- rst in any state: back to IDLE next edge, pending access dropped, no resp_valid; late mem_resp_valid ignored.
- resp_rdata/resp_err valid only while resp_valid; otherwise 0.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: addr not a multiple of bytes -> no memory beat, resp_err=1 at N+1, resp_rdata=0.
- Undefined: misaligned addresses silently rounded down to natural alignment; resp_err only for illegal size.

## Test plan
- DATA_WIDTH=64, sb addr 0x80000003 wdata 0xAB, zero-wait mem -> mem_req_addr 0x80000000, wstrb 0x08, wdata 0xAB000000, resp_valid at N+3, resp_err 0.
- lh addr 0x80000006, mem_resp_rdata 0x8001_0000_0000_0000 -> resp_rdata 0xFFFF_FFFF_FFFF_8001; lhu same -> 0x0000_0000_0000_8001.
- mem_req_ready low 3 cycles, resp 2 cycles later -> mem_req_* stable throughout, req_ready 0, single resp_valid at N+7.
- With LSU_MISALIGN_TRAP_EN, lw addr 0x80000002 -> no mem_req_valid, resp_valid+resp_err at N+1; without, beat at 0x80000000 wstrb 0x0F.
- DATA_WIDTH=32, ld any addr -> resp_err 1 at N+1, no memory beat.
- rst asserted in WAIT, then mem_resp_valid -> no resp_valid, state IDLE, req_ready 1.

Source files
------------

// File: rtl/ysyx_22040729_lsu.sv
// ysyx_22040729_lsu: load/store unit between the execute stage and a
// handshaked data-memory port. One access in flight; each access becomes a
// single aligned beat with byte strobes, and load data comes back lane-aligned
// and sign/zero-extended.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, accesses whose address is
// not a multiple of the access size are refused with resp_err and issue no
// memory beat. When undefined, such addresses are rounded down to natural
// alignment.
module ysyx_22040729_lsu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [2:0]              req_func3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_wen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;

  // Request captured at accept (p0) and extended load data (p1).
  logic                  wen_p0;
  logic [2:0]            func3_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic                  err_p0;
  logic [DATA_WIDTH-1:0] rdata_p1;

  logic                  accept;
  logic                  req_illegal;
  logic                  size_bad;
  logic                  misaligned;
  logic [2:0]            lo_mask;
  logic [OFFW-1:0]       off;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  // Byte enables: one bit per accessed byte, shifted to the lane offset.
  function automatic logic [NB-1:0] lane_strb(input logic [1:0] size,
                                              input logic [OFFW-1:0] lane);
    logic [15:0] m;
    case (size)
      2'd0:    m = 16'h0001;
      2'd1:    m = 16'h0003;
      2'd2:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m = m << lane;
    return m[NB-1:0];
  endfunction

  // Right-justify the addressed bytes and sign/zero-extend to the bus width.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] beat,
                                                     input logic [OFFW-1:0]       lane,
                                                     input logic [2:0]            f3);
    logic [DATA_WIDTH-1:0]        sh;
    logic signed [DATA_WIDTH-1:0] res;
    sh = beat >> {lane, 3'b000};
    case (f3[1:0])
      2'd0: begin
        if (f3[2]) res = DATA_WIDTH'(sh[7:0]);
        else       res = DATA_WIDTH'($signed(sh[7:0]));
      end
      2'd1: begin
        if (f3[2]) res = DATA_WIDTH'(sh[15:0]);
        else       res = DATA_WIDTH'($signed(sh[15:0]));
      end
      2'd2: begin
        if (f3[2]) res = DATA_WIDTH'(sh[31:0]);
        else       res = DATA_WIDTH'($signed(sh[31:0]));
      end
      default: res = sh;
    endcase
    return res;
  endfunction

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign size_bad = (NB == 4) && (req_func3[1:0] == 2'd3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [2:0] req_mask;
  assign req_mask   = align_mask(req_func3[1:0]);
  assign misaligned = |(req_addr[2:0] & req_mask);
`else
  assign misaligned = 1'b0;
`endif

  assign req_illegal = size_bad || misaligned;

  // Lane offset, rounded down to natural alignment (a no-op when traps
  // already guarantee aligned addresses).
  assign lo_mask = align_mask(func3_p0[1:0]);
  assign off     = addr_p0[OFFW-1:0] & ~lo_mask[OFFW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Error flag is control state and follows reset.
  always_ff @(posedge clk) begin
    if (rst)         err_p0 <= 1'b0;
    else if (accept) err_p0 <= req_illegal;
  end

  // Request and load-data capture; outputs are gated by state, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_p0   <= req_wen;
      func3_p0 <= req_func3;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
    if (state_q == S_WAIT && mem_resp_valid)
      rdata_p1 <= wen_p0 ? '0 : load_ext(mem_resp_rdata, off, func3_p0);
  end

  // Next-state and outputs; beat fields only driven in REQ, response only in RESP.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wen   = 1'b0;
    mem_req_addr  = '0;
    mem_req_wstrb = '0;
    mem_req_wdata = '0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_illegal ? S_RESP : S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wen   = wen_p0;
        mem_req_addr  = {addr_p0[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        mem_req_wstrb = lane_strb(func3_p0[1:0], off);
        mem_req_wdata = wdata_p0 << {off, 3'b000};
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_p0;
        resp_rdata = err_p0 ? '0 : rdata_p1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
